// File: rtl/gbf_chk_pkg.sv
// gbf_chk_pkg: shared lane state, armed-command type and saturating increment
package gbf_chk_pkg;
  typedef enum logic [1:0] {RUN, PEND, SETA} lane_st_t;
  typedef struct packed {logic lay; logic nxt; logic rst;} armed_t;
  localparam int CNT_W_DEF = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == (32'd1 << w) - 32'd1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/gbf_chk_lane.sv
// gbf_chk_lane: one checker lane - reference RAM, group table, command FSM, compare pipeline.
// First-error capture registers exist only when CHK_FIRST_ERR_CAPTURE_EN is defined.
module gbf_chk_lane import gbf_chk_pkg::*; #(
  parameter int DATA_WIDTH = 96,
  parameter int REF_AW = 12,
  parameter int GRP_AW = 6,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ld_ref,
  input  logic i_ld_tbl,
  input  logic [REF_AW-1:0] i_ld_addr,
  input  logic [DATA_WIDTH-1:0] i_ld_dat,
  input  logic i_cmd_lay,
  input  logic i_cmd_grp_rst,
  input  logic i_cmd_grp_next,
  input  logic i_wait_cfg,
  input  logic i_mon_en,
  input  logic [DATA_WIDTH-1:0] i_mon_dat,
  output logic o_err_pulse,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic o_wrap_flag,
  output logic o_busy,
  output logic o_fe_valid,
  output logic [REF_AW-1:0] o_fe_addr,
  output logic [DATA_WIDTH-1:0] o_fe_mon,
  output logic [DATA_WIDTH-1:0] o_fe_ref
);
  logic [DATA_WIDTH-1:0] r_ref [2**REF_AW];
  logic [REF_AW-1:0] r_tbl [2**GRP_AW];
  lane_st_t r_st;
  armed_t r_armed;
  logic r_wait_q, r_cmp_v, r_wrap;
  logic [REF_AW-1:0] r_addr, r_tbl_q;
  logic [GRP_AW-1:0] r_grp;
  logic [DATA_WIDTH-1:0] r_mon_q, r_ref_q;
  logic [CNT_W-1:0] r_err_cnt, r_drop_cnt;
  armed_t w_cmd;
  logic w_wneg, w_run_beat, w_mis, w_lay_only;
  logic [GRP_AW-1:0] w_grp_n;
  assign w_cmd = {i_cmd_lay, i_cmd_grp_next, i_cmd_grp_rst};
  assign w_wneg = r_wait_q & ~i_wait_cfg;
  assign w_grp_n = (r_armed.lay ? {GRP_AW{1'b0}} : r_grp) + GRP_AW'(r_armed.nxt);
  assign w_lay_only = r_armed == armed_t'(3'b100);
  assign w_run_beat = i_mon_en & (r_st == RUN);
  // reset suppresses the result of a beat still in the compare stage
  assign w_mis = r_cmp_v & ~rst & (r_mon_q != r_ref_q);
  assign o_err_pulse = w_mis;
  assign o_err_cnt = r_err_cnt;
  assign o_drop_cnt = r_drop_cnt;
  assign o_wrap_flag = r_wrap;
  assign o_busy = r_st != RUN;
  always_ff @(posedge clk) begin
    if (i_ld_ref) r_ref[i_ld_addr] <= i_ld_dat;
    if (i_ld_tbl) r_tbl[i_ld_addr[GRP_AW-1:0]] <= i_ld_dat[REF_AW-1:0];
    r_ref_q <= r_ref[r_addr];
    r_mon_q <= i_mon_dat;
    r_tbl_q <= r_tbl[w_grp_n];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= RUN;
      r_armed <= '0;
      r_wait_q <= 1'b0;
      r_cmp_v <= 1'b0;
      r_wrap <= 1'b0;
      r_addr <= '0;
      r_grp <= '0;
      r_err_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wait_q <= i_wait_cfg;
      r_cmp_v <= w_run_beat;
      if (w_mis) r_err_cnt <= CNT_W'(sat_inc(32'(r_err_cnt), CNT_W));
      if (i_mon_en && r_st != RUN) r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_W));
      if (w_run_beat) begin
        r_addr <= r_addr + REF_AW'(1);
        if (&r_addr) r_wrap <= 1'b1;
      end
      case (r_st)
        RUN: if (|w_cmd) begin
          r_st <= PEND;
          r_armed <= w_cmd;
        end
        PEND: if (w_wneg) begin
          r_grp <= w_grp_n;
          r_armed <= w_cmd;
          if (w_lay_only) begin
            r_addr <= '0;
            r_st <= |w_cmd ? PEND : RUN;
          end else r_st <= SETA;
        end else r_armed <= r_armed | w_cmd;
        SETA: begin
          r_addr <= r_tbl_q;
          r_armed <= r_armed | w_cmd;
          r_st <= |(r_armed | w_cmd) ? PEND : RUN;
        end
        default: r_st <= RUN;
      endcase
    end
  end
`ifdef CHK_FIRST_ERR_CAPTURE_EN
  logic r_fe_v;
  logic [REF_AW-1:0] r_addr_q, r_fe_addr;
  logic [DATA_WIDTH-1:0] r_fe_mon, r_fe_ref;
  always_ff @(posedge clk) begin
    r_addr_q <= r_addr;
    if (rst) begin
      r_fe_v <= 1'b0;
      r_fe_addr <= '0;
      r_fe_mon <= '0;
      r_fe_ref <= '0;
    end else if (w_mis && !r_fe_v) begin
      r_fe_v <= 1'b1;
      r_fe_addr <= r_addr_q;
      r_fe_mon <= r_mon_q;
      r_fe_ref <= r_ref_q;
    end else if (r_st == PEND && w_wneg && r_armed.lay) r_fe_v <= 1'b0;
  end
  assign o_fe_valid = r_fe_v;
  assign o_fe_addr = r_fe_addr;
  assign o_fe_mon = r_fe_mon;
  assign o_fe_ref = r_fe_ref;
`else
  assign o_fe_valid = 1'b0;
  assign o_fe_addr = '0;
  assign o_fe_mon = '0;
  assign o_fe_ref = '0;
`endif
endmodule

// File: rtl/gbf_stream_checker.sv
// gbf_stream_checker: NUM_CH-lane stream checker comparing monitored writes against preloaded reference words.
// First-error capture is built only when CHK_FIRST_ERR_CAPTURE_EN is defined.
module gbf_stream_checker import gbf_chk_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 96,
  parameter int REF_AW = 12,
  parameter int GRP_AW = 6,
  parameter int CNT_W = CNT_W_DEF,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_en,
  input  logic ld_tbl,
  input  logic [CHW-1:0] ld_ch,
  input  logic [REF_AW-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_dat,
  input  logic [NUM_CH-1:0] cmd_lay,
  input  logic [NUM_CH-1:0] cmd_grp_rst,
  input  logic [NUM_CH-1:0] cmd_grp_next,
  input  logic [NUM_CH-1:0] wait_cfg,
  input  logic [NUM_CH-1:0] mon_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] mon_dat,
  output logic [NUM_CH-1:0] err_pulse,
  output logic [NUM_CH*CNT_W-1:0] err_cnt,
  output logic [NUM_CH*CNT_W-1:0] drop_cnt,
  output logic [NUM_CH-1:0] wrap_flag,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] fe_valid,
  output logic [NUM_CH*REF_AW-1:0] fe_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] fe_mon,
  output logic [NUM_CH*DATA_WIDTH-1:0] fe_ref
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic w_sel;
    assign w_sel = ld_en && ld_ch == CHW'(i);
    gbf_chk_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .REF_AW(REF_AW),
      .GRP_AW(GRP_AW),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .i_ld_ref(w_sel & ~ld_tbl),
      .i_ld_tbl(w_sel & ld_tbl),
      .i_ld_addr(ld_addr),
      .i_ld_dat(ld_dat),
      .i_cmd_lay(cmd_lay[i]),
      .i_cmd_grp_rst(cmd_grp_rst[i]),
      .i_cmd_grp_next(cmd_grp_next[i]),
      .i_wait_cfg(wait_cfg[i]),
      .i_mon_en(mon_en[i]),
      .i_mon_dat(mon_dat[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_err_pulse(err_pulse[i]),
      .o_err_cnt(err_cnt[i*CNT_W +: CNT_W]),
      .o_drop_cnt(drop_cnt[i*CNT_W +: CNT_W]),
      .o_wrap_flag(wrap_flag[i]),
      .o_busy(busy[i]),
      .o_fe_valid(fe_valid[i]),
      .o_fe_addr(fe_addr[i*REF_AW +: REF_AW]),
      .o_fe_mon(fe_mon[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_fe_ref(fe_ref[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_gbf_stream_checker.sv
// tb_gbf_stream_checker: randomized stream checks against a per-lane reference model of addresses, groups and counters
module tb_gbf_stream_checker;
  localparam int NC = 4, DW = 96, RAW = 12, GAW = 6, CW = 16;
  localparam int DEPTH = 2**RAW, GDEPTH = 2**GAW, CMAX = 2**CW - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic ld_en, ld_tbl;
  logic [1:0] ld_ch;
  logic [RAW-1:0] ld_addr;
  logic [DW-1:0] ld_dat;
  logic [NC-1:0] cmd_lay, cmd_grp_rst, cmd_grp_next, wait_cfg, mon_en;
  logic [NC*DW-1:0] mon_dat;
  logic [NC-1:0] err_pulse, wrap_flag, busy, fe_valid;
  logic [NC*CW-1:0] err_cnt, drop_cnt;
  logic [NC*RAW-1:0] fe_addr;
  logic [NC*DW-1:0] fe_mon, fe_ref;
  logic [DW-1:0] m_ref [NC][DEPTH];
  logic [RAW-1:0] m_tbl [NC][GDEPTH];
  int m_addr [NC], m_grp [NC], m_err [NC], m_drop [NC];
  bit m_wrap [NC];
  int errors = 0, checks = 0;
  gbf_stream_checker u_dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_tbl(ld_tbl), .ld_ch(ld_ch), .ld_addr(ld_addr),
    .ld_dat(ld_dat), .cmd_lay(cmd_lay), .cmd_grp_rst(cmd_grp_rst), .cmd_grp_next(cmd_grp_next),
    .wait_cfg(wait_cfg), .mon_en(mon_en), .mon_dat(mon_dat), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt), .wrap_flag(wrap_flag), .busy(busy),
    .fe_valid(fe_valid), .fe_addr(fe_addr), .fe_mon(fe_mon), .fe_ref(fe_ref)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_addr[c] = 0; m_grp[c] = 0; m_err[c] = 0; m_drop[c] = 0; m_wrap[c] = 0;
    end
  endtask
  task automatic load(input bit tbl, input int ch, input int a, input logic [DW-1:0] d);
    ld_en = 1; ld_tbl = tbl; ld_ch = 2'(ch); ld_addr = RAW'(a); ld_dat = d;
    tick();
    ld_en = 0;
    if (tbl) m_tbl[ch][a % GDEPTH] = d[RAW-1:0];
    else m_ref[ch][a] = d;
  endtask
  // each beat's result is visible on err_pulse in the cycle right after it is sampled
  task automatic beat(input int ch, input logic [DW-1:0] d, input bit chk_en);
    bit exp_mis;
    exp_mis = d != m_ref[ch][m_addr[ch]];
    mon_en[ch] = 1; mon_dat[ch*DW +: DW] = d;
    tick();
    mon_en[ch] = 0;
    if (chk_en) chk("err_pulse", err_pulse[ch], exp_mis);
    if (exp_mis) m_err[ch] = m_err[ch] < CMAX ? m_err[ch] + 1 : CMAX;
    if (m_addr[ch] == DEPTH-1) m_wrap[ch] = 1;
    m_addr[ch] = (m_addr[ch] + 1) % DEPTH;
  endtask
  task automatic rbeat(input int ch, input bit force_match);
    beat(ch, (!force_match && $urandom_range(0, 3) == 0) ? rnd() : m_ref[ch][m_addr[ch]], 1);
  endtask
  task automatic drop_beat(input int ch);
    mon_en[ch] = 1; mon_dat[ch*DW +: DW] = rnd();
    tick();
    mon_en[ch] = 0;
    chk("drop_no_pulse", err_pulse[ch], 0);
    m_drop[ch] = m_drop[ch] < CMAX ? m_drop[ch] + 1 : CMAX;
  endtask
  task automatic command(input int ch, input bit lay, input bit nxt, input bit rs, input int ndrop);
    int g;
    wait_cfg[ch] = 1; cmd_lay[ch] = lay; cmd_grp_next[ch] = nxt; cmd_grp_rst[ch] = rs;
    tick();
    cmd_lay[ch] = 0; cmd_grp_next[ch] = 0; cmd_grp_rst[ch] = 0;
    chk("busy_pend", busy[ch], 1);
    repeat (ndrop) drop_beat(ch);
    wait_cfg[ch] = 0;
    tick();
    tick();
    chk("busy_released", busy[ch], 0);
    g = lay ? 0 : m_grp[ch];
    if (nxt) g = (g + 1) % GDEPTH;
    m_grp[ch] = g;
    m_addr[ch] = (lay && !nxt && !rs) ? 0 : int'(m_tbl[ch][g]);
  endtask
  task automatic chk_cnt(input int ch);
    tick();
    chk("err_cnt", err_cnt[ch*CW +: CW], m_err[ch]);
    chk("drop_cnt", drop_cnt[ch*CW +: CW], m_drop[ch]);
    chk("wrap_flag", wrap_flag[ch], m_wrap[ch]);
  endtask
  initial begin
    ld_en = 0; ld_tbl = 0; ld_ch = 0; ld_addr = 0; ld_dat = 0;
    cmd_lay = 0; cmd_grp_rst = 0; cmd_grp_next = 0; wait_cfg = 0; mon_en = 0; mon_dat = 0;
    model_reset();
    repeat (3) tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_wrap", wrap_flag, 0);
    chk("rst_fe_valid", fe_valid, 0);
    for (int k = 0; k < 8; k++) load(0, 0, k, DW'(k * 'h11));
    for (int k = 0; k < 8; k++) beat(0, m_ref[0][k], 1);
    chk_cnt(0);
    command(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) beat(0, k == 3 ? DW'('hDEAD) : m_ref[0][k], 1);
    chk_cnt(0);
    chk("single_mis_cnt", err_cnt[CW-1:0], 1);
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    chk("fe_valid", fe_valid[0], 1);
    chk("fe_addr", fe_addr[RAW-1:0], 3);
    chk("fe_mon", fe_mon[DW-1:0], 'hDEAD);
    chk("fe_ref", fe_ref[DW-1:0], 'h33);
`else
    chk("fe_valid_off", fe_valid, 0);
    chk("fe_mon_off", fe_mon, 0);
`endif
    for (int k = 0; k < 4; k++) load(0, 1, k, rnd());
    for (int k = 0; k < 4; k++) rbeat(1, k == 0);
    chk_cnt(1);
    chk_cnt(0);
    for (int a = 8; a < DEPTH; a++) load(0, 0, a, rnd());
    load(1, 0, 0, 0);
    load(1, 0, 1, 16);
    load(1, 0, 2, 40);
    command(0, 0, 1, 0, 5);
    chk("drop_five", drop_cnt[CW-1:0], 5);
    for (int k = 0; k < 6; k++) rbeat(0, k == 0);
    chk_cnt(0);
    command(0, 0, 1, 0, $urandom_range(0, 4));
    for (int k = 0; k < 6; k++) rbeat(0, k == 0);
    chk_cnt(0);
    command(0, 1, 1, 0, $urandom_range(0, 4));
    for (int k = 0; k < 6; k++) rbeat(0, k == 0);
    command(0, 0, 0, 1, $urandom_range(0, 4));
    for (int k = 0; k < 6; k++) rbeat(0, k == 0);
    chk_cnt(0);
    command(0, 1, 0, 0, 0);
    for (int n = 0; n < CMAX + 5; n++) begin
      beat(0, n == DEPTH ? m_ref[0][m_addr[0]] : ~m_ref[0][m_addr[0]], n < DEPTH + 4);
      if (n == DEPTH-2) chk("wrap_before", wrap_flag[0], 0);
      if (n == DEPTH-1) chk("wrap_set", wrap_flag[0], 1);
    end
    chk_cnt(0);
    chk("err_saturated", err_cnt[CW-1:0], 16'hFFFF);
    wait_cfg[0] = 1; cmd_grp_next[0] = 1; mon_en[0] = 1; mon_dat[DW-1:0] = ~m_ref[0][m_addr[0]];
    tick();
    cmd_grp_next[0] = 0; mon_en[0] = 0; rst = 1;
    chk("pend_before_rst", busy[0], 1);
    #1;
    chk("rst_no_pulse", err_pulse[0], 0);
    tick();
    rst = 0; wait_cfg[0] = 0;
    model_reset();
    chk("post_rst_pulse", err_pulse[0], 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_drop", drop_cnt, 0);
    for (int k = 0; k < 5; k++) rbeat(0, k == 0);
    chk_cnt(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
